// File: rtl/uart_rx_fifo_param.sv
// UART receiver: oversampled mid-bit sampling, parity/stop checks, break detect,
// sticky error flags and a first-word-fall-through receive FIFO.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a 1->0 edge on rx_s
// S_START  | start bit, sampled at its mid-point to reject glitches
// S_DATA   | shifting in DATA_BITS samples, LSB first
// S_PARITY | parity bit sample (parity modes 01/10 only)
// S_STOP1  | first stop bit sample
// S_STOP2  | second stop bit sample (two_stop_bits latched high)
// S_CHECK  | one cycle: break / frame / parity decision, FIFO store
// S_BRK    | break seen, waiting for the line to return high
module uart_rx_fifo_param #(
   parameter int DATA_BITS   = 8,
   parameter int FIFO_DEPTH  = 16,
   parameter int OVS         = 16,
   parameter int DIV_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [DIV_W-1:0]              baud_div,
   input  logic [1:0]                    parity_mode,
   input  logic                          two_stop_bits,
   input  logic                          rx_in,
   input  logic                          rd_en,
   input  logic                          err_clr,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overrun_err,
   output logic                          break_det
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(OVS);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_CHECK, S_BRK
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s, rx_prev_q;
   logic [DIV_W-1:0]       div_cnt_q, div_cnt_d, div_q, div_d;
   logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic                   par_bit_q, par_bit_d, stop1_q, stop1_d, stop2_q, stop2_d;
   logic                   two_q, two_d;
   logic [1:0]             pmode_q, pmode_d;
   logic                   tick, mid_start, mid_bit, par_en, par_bad, is_brk;
   logic                   store_req, set_perr, set_ferr, set_oerr;

   logic [DATA_BITS-1:0]   mem_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [AW:0]            count_q, count_d;
   logic                   full, push, pop;
   logic                   perr_q, ferr_q, oerr_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q    <= '1;
         rx_prev_q <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_in};
         rx_prev_q <= rx_s;
      end
   end

   assign rx_s      = sync_q[SYNC_STAGES-1];
   assign tick      = (div_cnt_q == div_q);
   assign mid_start = tick && (tick_cnt_q == TW'(OVS/2 - 1));
   assign mid_bit   = tick && (tick_cnt_q == TW'(OVS - 1));
   assign par_en    = pmode_q[0] ^ pmode_q[1];
   // odd mode (10) wants the XOR over data and parity bit to be 1
   assign par_bad   = ((^shift_q) ^ par_bit_q) != pmode_q[1];
   assign is_brk    = (shift_q == '0) && !(par_en && par_bit_q) && !stop1_q;

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
      tick_cnt_d = tick ? tick_cnt_q + 1'b1 : tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_bit_d  = par_bit_q;
      stop1_d    = stop1_q;
      stop2_d    = stop2_q;
      div_d      = div_q;
      pmode_d    = pmode_q;
      two_d      = two_q;
      store_req  = 1'b0;
      set_perr   = 1'b0;
      set_ferr   = 1'b0;
      case (state_q)
         S_IDLE: begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
            if (rx_prev_q && !rx_s) begin
               state_d = S_START;
               div_d   = baud_div;
               pmode_d = parity_mode;
               two_d   = two_stop_bits;
            end
         end
         S_START: if (mid_start) begin
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            state_d    = rx_s ? S_IDLE : S_DATA;
         end
         S_DATA: if (mid_bit) begin
            tick_cnt_d = '0;
            shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(DATA_BITS - 1))
               state_d = par_en ? S_PARITY : S_STOP1;
         end
         S_PARITY: if (mid_bit) begin
            tick_cnt_d = '0;
            par_bit_d  = rx_s;
            state_d    = S_STOP1;
         end
         S_STOP1: if (mid_bit) begin
            tick_cnt_d = '0;
            stop1_d    = rx_s;
            stop2_d    = 1'b1;
            state_d    = two_q ? S_STOP2 : S_CHECK;
         end
         S_STOP2: if (mid_bit) begin
            tick_cnt_d = '0;
            stop2_d    = rx_s;
            state_d    = S_CHECK;
         end
         S_CHECK: begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
            state_d    = S_IDLE;
            if (is_brk)                  state_d   = S_BRK;
            else if (!stop1_q || !stop2_q) set_ferr = 1'b1;
            else if (par_en && par_bad)  set_perr  = 1'b1;
            else                         store_req = 1'b1;
         end
         S_BRK: begin
            div_cnt_d  = '0;
            tick_cnt_d = '0;
            if (rx_s) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         div_cnt_q  <= '0;
         div_q      <= '0;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_bit_q  <= 1'b0;
         stop1_q    <= 1'b1;
         stop2_q    <= 1'b1;
         two_q      <= 1'b0;
         pmode_q    <= 2'b00;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         div_q      <= div_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_bit_q  <= par_bit_d;
         stop1_q    <= stop1_d;
         stop2_q    <= stop2_d;
         two_q      <= two_d;
         pmode_q    <= pmode_d;
      end
   end

   // a pop in the store cycle frees the slot, so a full FIFO still accepts the frame
   assign full     = (count_q == FULL_CNT);
   assign pop      = rd_en && (count_q != '0);
   assign push     = store_req && (!full || rd_en);
   assign set_oerr = store_req && full && !rd_en;

   always_comb begin
      count_d = count_q;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= shift_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         oerr_q   <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         perr_q  <= set_perr | (perr_q & ~err_clr);
         ferr_q  <= set_ferr | (ferr_q & ~err_clr);
         oerr_q  <= set_oerr | (oerr_q & ~err_clr);
      end
   end

   assign rd_valid    = (count_q != '0);
   assign rd_data     = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign fifo_count  = count_q;
   assign parity_err  = perr_q;
   assign frame_err   = ferr_q;
   assign overrun_err = oerr_q;
   assign break_det   = (state_q == S_CHECK) && is_brk;

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
// Directed bench for uart_rx_fifo_param: frame table plus overrun, break,
// glitch, error-clear priority and mid-frame reset sequences.
module tb_uart_rx_fifo_param;

   localparam int BIT = 64;           // OVS=16 ticks x (baud_div+1)=4 clocks
   localparam int LAT_8N1 = 612;      // start-edge drive to rd_valid high, 8N1

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic        two_stop_bits, rx_in, rd_en, err_clr;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [4:0]  fifo_count;
   logic        parity_err, frame_err, overrun_err, break_det;

   int total = 0;
   int bad = 0;
   int brk_cnt = 0;

   always #5 clk = ~clk;

   uart_rx_fifo_param dut (
      .clk(clk), .reset_n(reset_n), .baud_div(baud_div), .parity_mode(parity_mode),
      .two_stop_bits(two_stop_bits), .rx_in(rx_in), .rd_en(rd_en), .err_clr(err_clr),
      .rd_data(rd_data), .rd_valid(rd_valid), .fifo_count(fifo_count),
      .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err),
      .break_det(break_det)
   );

   always @(negedge clk) if (break_det) brk_cnt++;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] pm;
      logic       two;
      logic       pb;
      logic       sb;
      logic       good;
      logic       perr;
      logic       ferr;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
      end
   endtask

   // Drives one frame plus one idle bit time; rd_at/clr_at pulse rd_en/err_clr
   // at that cycle offset from the start-bit drive; lat = offset of rd_valid rise.
   task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic two,
                             input logic pb, input logic sb, input int rd_at,
                             input int clr_at, output int lat);
      logic [11:0] bits;
      int n;
      logic prev_v;
      bits = '1;
      bits[0] = 1'b0;
      bits[8:1] = d;
      n = 9;
      if (pm == 2'b01 || pm == 2'b10) begin bits[n] = pb; n++; end
      bits[n] = sb; n++;
      if (two) begin bits[n] = 1'b1; n++; end
      parity_mode = pm;
      two_stop_bits = two;
      lat = -1;
      prev_v = rd_valid;
      for (int k = 0; k < (n + 1) * BIT; k++) begin
         @(negedge clk);
         if (lat < 0 && rd_valid && !prev_v) lat = k;
         prev_v = rd_valid;
         rx_in = (k < n * BIT) ? bits[k / BIT] : 1'b1;
         rd_en = (k == rd_at);
         err_clr = (k == clr_at);
      end
      rd_en = 1'b0;
      err_clr = 1'b0;
   endtask

   task automatic clear_all();
      @(negedge clk);
      err_clr = 1'b1;
      rd_en = 1'b1;
      repeat (18) @(negedge clk);
      err_clr = 1'b0;
      rd_en = 1'b0;
      @(negedge clk);
   endtask

   task automatic pulse_clr();
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   vec_t vecs[10];
   int   lat, exp_lat, b0;

   initial begin
      vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[1] = '{8'h3C, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'h3C, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'h01, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{8'h00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[7] = '{8'h80, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{8'hFF, 2'b01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[9] = '{8'hC3, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

      reset_n = 1'b0;
      baud_div = 16'd3;
      parity_mode = 2'b00;
      two_stop_bits = 1'b0;
      rx_in = 1'b1;
      rd_en = 1'b0;
      err_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset rd_valid", rd_valid, 0);
      chk("reset fifo_count", fifo_count, 0);
      chk("reset rd_data", rd_data, 0);
      chk("reset errors", {parity_err, frame_err, overrun_err, break_det}, 0);
      reset_n = 1'b1;
      repeat (BIT) @(negedge clk);

      for (int i = 0; i < 10; i++) begin
         clear_all();
         b0 = brk_cnt;
         send_frame(vecs[i].data, vecs[i].pm, vecs[i].two, vecs[i].pb, vecs[i].sb, -1, -1, lat);
         exp_lat = LAT_8N1;
         if (vecs[i].pm == 2'b01 || vecs[i].pm == 2'b10) exp_lat += BIT;
         if (vecs[i].two) exp_lat += BIT;
         if (!vecs[i].good) exp_lat = -1;
         chk($sformatf("v%0d rd_valid", i), rd_valid, vecs[i].good);
         chk($sformatf("v%0d rd_data", i), rd_data, vecs[i].good ? vecs[i].data : 8'h00);
         chk($sformatf("v%0d fifo_count", i), fifo_count, vecs[i].good ? 1 : 0);
         chk($sformatf("v%0d parity_err", i), parity_err, vecs[i].perr);
         chk($sformatf("v%0d frame_err", i), frame_err, vecs[i].ferr);
         chk($sformatf("v%0d overrun_err", i), overrun_err, 0);
         chk($sformatf("v%0d latency", i), lat, exp_lat);
         chk($sformatf("v%0d break pulses", i), brk_cnt - b0, 0);
      end

      // parity error then err_clr
      clear_all();
      send_frame(8'h3C, 2'b01, 1'b1, 1'b1, 1'b1, -1, -1, lat);
      chk("perr set", parity_err, 1);
      pulse_clr();
      chk("perr cleared", parity_err, 0);

      // err_clr in the check cycle loses to the set (8E1 check at offset 675)
      clear_all();
      send_frame(8'hFF, 2'b01, 1'b0, 1'b1, 1'b1, -1, LAT_8N1 + BIT - 1, lat);
      chk("set beats clr", parity_err, 1);

      // break: line low for two frame times
      clear_all();
      b0 = brk_cnt;
      parity_mode = 2'b00;
      two_stop_bits = 1'b0;
      @(negedge clk);
      rx_in = 1'b0;
      repeat (2 * 10 * BIT) @(negedge clk);
      rx_in = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      chk("break pulses", brk_cnt - b0, 1);
      chk("break fifo_count", fifo_count, 0);
      chk("break frame_err", frame_err, 0);
      chk("break parity_err", parity_err, 0);

      // glitch shorter than half a bit
      clear_all();
      b0 = brk_cnt;
      @(negedge clk);
      rx_in = 1'b0;
      repeat (16) @(negedge clk);
      rx_in = 1'b1;
      repeat (3 * BIT) @(negedge clk);
      chk("glitch fifo_count", fifo_count, 0);
      chk("glitch errors", {parity_err, frame_err, overrun_err}, 0);
      chk("glitch break", brk_cnt - b0, 0);

      // overrun: 17 frames, no reads
      clear_all();
      for (int i = 1; i <= 17; i++)
         send_frame(8'(i), 2'b00, 1'b0, 1'b0, 1'b1, -1, -1, lat);
      chk("ovr fifo_count", fifo_count, 16);
      chk("ovr overrun_err", overrun_err, 1);
      for (int i = 1; i <= 16; i++) begin
         chk($sformatf("ovr pop %0d", i), rd_data, i);
         @(negedge clk);
         rd_en = 1'b1;
         @(negedge clk);
         rd_en = 1'b0;
      end
      chk("ovr drained", {rd_valid, fifo_count}, 0);
      chk("ovr sticky", overrun_err, 1);
      pulse_clr();
      chk("ovr cleared", overrun_err, 0);

      // full FIFO with a pop in the store cycle
      clear_all();
      for (int i = 0; i < 16; i++)
         send_frame(8'h40 + 8'(i), 2'b00, 1'b0, 1'b0, 1'b1, -1, -1, lat);
      chk("full count", fifo_count, 16);
      send_frame(8'hEE, 2'b00, 1'b0, 1'b0, 1'b1, LAT_8N1 - 1, -1, lat);
      chk("full+pop count", fifo_count, 16);
      chk("full+pop overrun", overrun_err, 0);
      chk("full+pop head", rd_data, 8'h41);
      @(negedge clk);
      rd_en = 1'b1;
      repeat (15) @(negedge clk);
      rd_en = 1'b0;
      chk("full+pop tail", rd_data, 8'hEE);
      chk("full+pop last count", fifo_count, 1);

      // reset in the middle of a frame
      clear_all();
      send_frame(8'h77, 2'b00, 1'b0, 1'b0, 1'b1, -1, -1, lat);
      send_frame(8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, -1, -1, lat);
      chk("pre-reset state", {rd_valid, parity_err, rd_data}, {1'b1, 1'b1, 8'h77});
      parity_mode = 2'b00;
      @(negedge clk);
      rx_in = 1'b0;
      repeat (BIT) @(negedge clk);
      rx_in = 1'b1;
      repeat (20) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst rd_valid", rd_valid, 0);
      chk("midrst fifo_count", fifo_count, 0);
      chk("midrst rd_data", rd_data, 0);
      chk("midrst flags", {parity_err, frame_err, overrun_err, break_det}, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (2 * BIT) @(negedge clk);
      chk("post-rst idle", fifo_count, 0);
      send_frame(8'h5A, 2'b00, 1'b0, 1'b0, 1'b1, -1, -1, lat);
      chk("post-rst data", {rd_valid, rd_data}, {1'b1, 8'h5A});
      chk("post-rst count", fifo_count, 1);
      chk("post-rst latency", lat, LAT_8N1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
